// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear, per-bit blinking from a shared
// programmable prescaler, and readback of the effective pin state.

module pio_out_lane #(
  parameter bit RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wr_data_i,
  input  logic wr_set_i,
  input  logic wr_clr_i,
  input  logic wr_en_i,
  input  logic wd_i,
  input  logic phase_i,
  output logic data_o,
  output logic en_o,
  output logic out_o
);
  logic data_q, data_d;
  logic en_q, en_d;

  always_comb begin
    data_d = data_q;
    if (wr_data_i)              data_d = wd_i;
    else if (wr_set_i && wd_i)  data_d = 1'b1;
    else if (wr_clr_i && wd_i)  data_d = 1'b0;
  end

  always_comb begin
    en_d = en_q;
    if (wr_en_i) en_d = wd_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RST_BIT;
      en_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  // Pure AND of flop outputs: no decode glitches reach the pin.
  assign out_o  = data_q & (~en_q | phase_i);
  assign data_o = data_q;
  assign en_o   = en_q;
endmodule

module pio_out_blink #(
  parameter int unsigned               WIDTH        = 8,
  parameter logic [WIDTH-1:0]          RESET_VALUE  = '0,
  parameter int unsigned               PERIOD_WIDTH = 24,
  parameter logic [PERIOD_WIDTH-1:0]   PERIOD_RESET = PERIOD_WIDTH'(12499999)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_BLINK  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_PINS   = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;

  logic wr;
  logic wr_data, wr_en, wr_per, wr_set, wr_clr;
  logic [WIDTH-1:0] data, blink_en;
  logic [PERIOD_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
  logic phase_q, phase_d;
  logic unused_wd;

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr && (address == A_DATA);
  assign wr_en   = wr && (address == A_BLINK);
  assign wr_per  = wr && (address == A_PERIOD);
  assign wr_set  = wr && (address == A_SET);
  assign wr_clr  = wr && (address == A_CLR);

  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_out_lane #(.RST_BIT(RESET_VALUE[i])) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_data_i (wr_data),
      .wr_set_i  (wr_set),
      .wr_clr_i  (wr_clr),
      .wr_en_i   (wr_en),
      .wd_i      (writedata[i]),
      .phase_i   (phase_q),
      .data_o    (data[i]),
      .en_o      (blink_en[i]),
      .out_o     (out_port[i])
    );
  end

  // A period write restarts the blink cycle and wins over a same-cycle wrap.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr_per) begin
      period_d = writedata[PERIOD_WIDTH-1:0];
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= PERIOD_RESET;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]        = data;
      A_BLINK:  readdata[WIDTH-1:0]        = blink_en;
      A_PERIOD: readdata[PERIOD_WIDTH-1:0] = period_q;
      A_PINS:   readdata[WIDTH-1:0]        = out_port;
      default:  readdata = '0;
    endcase
  end
endmodule
